// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the keypad digit path.
// Holds the emitter FSM state encoding, BCD nibble width, the double-dabble
// add-3 threshold and the keypad key-code width.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        EMIT    = 2'd2
    } state_t;

    localparam int BCD_W = 4;
    localparam int KEY_W = 8;

    // Nibbles at or above this value get 3 added before each shift.
    localparam logic [BCD_W-1:0] ADD3_THRESH = 4'd5;
    localparam logic [BCD_W-1:0] ADD3_VAL    = 4'd3;

    // Decimal digits needed to hold any DATA_W-bit unsigned value:
    // floor(w * log10(2)) + 1, with log10(2) approximated as 0.30103.
    function automatic int min_digits(input int w);
        return (w * 30103) / 100000 + 1;
    endfunction

endpackage

// File: rtl/bin2bcd_core.sv
// bin2bcd_core: double-dabble datapath, one binary bit per step.
// load captures the binary value and clears the BCD register; each step
// applies add-3 to every nibble >= 5 and shifts the shift-register MSB in.
module bin2bcd_core
    import keypad_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 10
)
(
    input  logic                          hwclk,
    input  logic                          reset,
    input  logic                          load,
    input  logic                          step,
    input  logic [DATA_W-1:0]             value,
    output logic [NUM_DIGITS*BCD_W-1:0]   bcd
);

    localparam int BCD_TOTAL = NUM_DIGITS * BCD_W;

    logic [DATA_W-1:0]    shift_reg;
    logic [BCD_TOTAL-1:0] bcd_reg;
    logic [BCD_TOTAL-1:0] bcd_adj;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign bcd_adj[gi*BCD_W +: BCD_W] =
                (bcd_reg[gi*BCD_W +: BCD_W] >= ADD3_THRESH)
                    ? bcd_reg[gi*BCD_W +: BCD_W] + ADD3_VAL
                    : bcd_reg[gi*BCD_W +: BCD_W];
        end
    endgenerate

    // Load on accepted start, otherwise adjust-and-shift one bit per step.
    // The top adjusted bit falls off the end; with enough digits it is always 0.
    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            shift_reg <= '0;
            bcd_reg   <= '0;
        end else if (load) begin
            shift_reg <= value;
            bcd_reg   <= '0;
        end else if (step) begin
            bcd_reg   <= BCD_TOTAL'({bcd_adj, shift_reg[DATA_W-1]});
            shift_reg <= shift_reg << 1;
        end
    end

    assign bcd = bcd_reg;

endmodule

// File: rtl/digit_emitter.sv
// digit_emitter: converts an unsigned binary value to decimal and streams the
// digits most-significant first over a valid/ready key interface.
// Optional feature macro LEADING_ZERO_SUPPRESS_EN: when defined, emission
// starts at the highest nonzero digit (value 0 still emits a single 0).
module digit_emitter
    import keypad_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_DIGITS = 10
)
(
    input  logic              hwclk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] value,
    output logic [KEY_W-1:0]  key,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              last,
    output logic              busy
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = $clog2(DATA_W + 1);

    generate
        if (NUM_DIGITS < min_digits(DATA_W)) begin : g_bad_cfg
            $error("digit_emitter: NUM_DIGITS too small for DATA_W");
        end
    endgenerate

    state_t                        state;
    logic [CNT_W-1:0]              bit_cnt;
    logic [IDX_W-1:0]              idx;
    logic [IDX_W-1:0]              next_idx;
    logic [IDX_W-1:0]              first_idx;
    logic [NUM_DIGITS*BCD_W-1:0]   bcd;
    logic [BCD_W-1:0]              digit [NUM_DIGITS];
    logic                          load;
    logic                          step;

    assign load     = (state == IDLE) && start;
    assign step     = (state == CONVERT);
    assign busy     = (state != IDLE);
    assign next_idx = idx - IDX_W'(1);

    bin2bcd_core #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_core (
        .hwclk (hwclk),
        .reset (reset),
        .load  (load),
        .step  (step),
        .value (value),
        .bcd   (bcd)
    );

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign digit[gi] = bcd[gi*BCD_W +: BCD_W];
        end
    endgenerate

`ifdef LEADING_ZERO_SUPPRESS_EN
    logic [IDX_W-1:0] lead_idx;

    // Scan units upward so the highest nonzero digit wins; all-zero gives 0.
    always_comb begin
        lead_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit[i] != '0) lead_idx = IDX_W'(i);
        end
    end

    assign first_idx = lead_idx;
`else
    assign first_idx = idx;
`endif

    function automatic logic [KEY_W-1:0] to_key(input logic [BCD_W-1:0] d);
        return {{(KEY_W-BCD_W){1'b0}}, d};
    endfunction

    // Control FSM: accept start, count DATA_W convert steps, then present
    // digits with registered key/key_valid/last and advance on handshake.
    always_ff @(posedge hwclk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            idx       <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            last      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= CONVERT;
                        bit_cnt <= CNT_W'(DATA_W);
                    end
                end
                CONVERT: begin
                    bit_cnt <= bit_cnt - CNT_W'(1);
                    if (bit_cnt == CNT_W'(1)) begin
                        state <= EMIT;
                        idx   <= IDX_W'(NUM_DIGITS - 1);
                    end
                end
                EMIT: begin
                    if (!key_valid) begin
                        // First EMIT cycle: BCD is final, present the lead digit.
                        idx       <= first_idx;
                        key       <= to_key(digit[first_idx]);
                        last      <= (first_idx == '0);
                        key_valid <= 1'b1;
                    end else if (key_ready) begin
                        if (last) begin
                            state     <= IDLE;
                            key       <= '0;
                            key_valid <= 1'b0;
                            last      <= 1'b0;
                        end else begin
                            idx  <= next_idx;
                            key  <= to_key(digit[next_idx]);
                            last <= (next_idx == '0);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    key_valid <= 1'b0;
                    last      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_emitter.sv
// tb_digit_emitter: randomized self-checking bench for digit_emitter.
// Expected digits come from plain decimal arithmetic on the input value.
module tb_digit_emitter;

    localparam int DATA_W     = 32;
    localparam int NUM_DIGITS = 10;

    logic              hwclk     = 1'b0;
    logic              reset     = 1'b0;
    logic              start     = 1'b0;
    logic [DATA_W-1:0] value     = '0;
    logic              key_ready = 1'b0;
    logic [7:0]        key;
    logic              key_valid;
    logic              last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 hwclk = ~hwclk;

    digit_emitter #(
        .DATA_W     (DATA_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) dut (
        .hwclk     (hwclk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .key       (key),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .last      (last),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // mode 0: plain, mode 1: extra start (value 99) during CONVERT,
    // mode 2: reset pulse while stalled on digit stall_at.
    // Called at a negedge; returns at a negedge with the DUT idle.
    task automatic run_value(input logic [31:0] v, input int stall_at, input int mode, input bit rnd_ready);
        int         dq[$];
        logic [63:0] t;
        logic [63:0] acc;
        int         k;
        int         stalls;
        int         bad;
        t   = 64'(v);
        acc = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            dq.push_front(int'(t % 64'd10));
            t = t / 64'd10;
        end
`ifdef LEADING_ZERO_SUPPRESS_EN
        while (dq.size() > 1 && dq[0] == 0) void'(dq.pop_front());
`endif
        start     = 1'b1;
        value     = v;
        key_ready = 1'b1;
        @(posedge hwclk);
        k = 0;
        while (k < 100) begin
            @(negedge hwclk);
            if (key_valid) break;
            if (k == 2) check("busy_convert", 64'(busy), 64'd1);
            if (mode == 1 && k == 4) begin
                start = 1'b1;
                value = 32'd99;
            end else begin
                start = 1'b0;
                value = $urandom;
            end
            @(posedge hwclk);
            k++;
        end
        start = 1'b0;
        if (k >= 100) begin
            check("kv_timeout", 64'(k), 64'(DATA_W + 1));
            return;
        end
`ifdef LEADING_ZERO_SUPPRESS_EN
        check("kv_latency_le", 64'(k >= DATA_W + 1 && k <= DATA_W + 2), 64'd1);
`else
        check("kv_latency", 64'(k), 64'(DATA_W + 1));
`endif
        for (int i = 0; i < dq.size(); i++) begin
            check("key_valid", 64'(key_valid), 64'd1);
            check("key", 64'(key), 64'(dq[i]));
            check("last", 64'(last), 64'(i == dq.size() - 1));
            acc = acc * 64'd10 + 64'(key);
            if (mode == 2 && i == stall_at) begin
                key_ready = 1'b0;
                @(negedge hwclk);
                #2 reset = 1'b0;
                #1;
                check("rst_mid_kv", 64'(key_valid), 64'd0);
                check("rst_mid_busy", 64'(busy), 64'd0);
                check("rst_mid_key", 64'(key), 64'd0);
                check("rst_mid_last", 64'(last), 64'd0);
                @(negedge hwclk);
                @(negedge hwclk);
                reset     = 1'b1;
                key_ready = 1'b1;
                bad       = 0;
                repeat (40) begin
                    @(negedge hwclk);
                    if (key_valid || busy) bad++;
                end
                check("no_digit_after_reset", 64'(bad), 64'd0);
                $display("TXN value=%0d abandoned_at_digit=%0d", v, i);
                return;
            end
            stalls = (i == stall_at) ? 5 : ((rnd_ready && $urandom_range(0, 3) == 0) ? 1 : 0);
            repeat (stalls) begin
                key_ready = 1'b0;
                @(negedge hwclk);
                check("stall_kv", 64'(key_valid), 64'd1);
                check("stall_key", 64'(key), 64'(dq[i]));
                check("stall_last", 64'(last), 64'(i == dq.size() - 1));
            end
            key_ready = 1'b1;
            @(negedge hwclk);
        end
        check("busy_after", 64'(busy), 64'd0);
        check("kv_after", 64'(key_valid), 64'd0);
        check("roundtrip", acc, 64'(v));
        $display("TXN value=%0d digits=%0d latency=%0d", v, dq.size(), k);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge hwclk);
        check("rst_key", 64'(key), 64'd0);
        check("rst_kv", 64'(key_valid), 64'd0);
        check("rst_last", 64'(last), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        // Release reset and request in the same cycle: first edge must accept.
        reset = 1'b1;
        run_value(32'd1234, -1, 0, 1'b0);
        run_value(32'hFFFF_FFFF, -1, 0, 1'b0);
        run_value(32'd1234567, 2, 0, 1'b0);
        run_value(32'd4242, -1, 1, 1'b0);
        run_value(32'd0, -1, 0, 1'b0);
        run_value(32'd987654321, 3, 2, 1'b0);
        run_value(32'd5, -1, 0, 1'b0);
        for (int n = 0; n < 1000; n++) begin
            run_value($urandom, ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 3)) : -1, 0, 1'b1);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_emitter.md
DIGIT_EMITTER -- requirements
Module: digit_emitter

Interface
REQ-001 Param DATA_W, default 32: width of the binary value to be emitted.
REQ-002 Param NUM_DIGITS, default 10: BCD digit capacity; shall be >= ceil(DATA_W*log10(2)), otherwise elaboration error.
REQ-003 hwclk  in  1  single clock; all state on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to emit value; accepted only in IDLE.
REQ-006 value  in  DATA_W  unsigned binary value; sampled on an accepted start.
REQ-007 key  out  8  current decimal digit, 0..9 zero-extended; same encoding as keypad key codes.
REQ-008 key_valid  out  1  key holds a digit awaiting acceptance.
REQ-009 key_ready  in  1  consumer accepts key when key_valid && key_ready.
REQ-010 last  out  1  qualifies key_valid; marks the least-significant digit.
REQ-011 busy  out  1  high in any state other than IDLE.

Function
REQ-012 FSM states IDLE, CONVERT, EMIT; busy = (state != IDLE).
REQ-013 IDLE: start=1 latches value, clears the BCD register, loads bit counter with DATA_W, enters CONVERT next cycle.
REQ-014 start outside IDLE is ignored, with no effect on the in-flight conversion.
REQ-015 CONVERT: double-dabble, one bit per cycle: add 3 to every BCD nibble >= 5, then shift left, MSB of shift register in; exactly DATA_W cycles.
REQ-016 After the last CONVERT cycle enter EMIT; key_valid rises DATA_W+1 cycles after the start edge.
REQ-017 EMIT: key is presented most-significant digit first; index advances only on key_valid && key_ready.
REQ-018 key, key_valid and last remain stable while key_valid && !key_ready (no drop, no change).
REQ-019 last=1 exactly on digit index 0 (units); the handshake on it returns the FSM to IDLE next cycle, key_valid=0.
REQ-020 Without leading-zero suppression, exactly NUM_DIGITS digits are emitted, including leading zeros.
REQ-021 Digits are unsigned 0..9; key[7:4] is always 0.
REQ-022 Back-to-back: start may be accepted in the cycle immediately after the last handshake (IDLE).

Reset
REQ-023 reset=0 asynchronously forces state IDLE, key=0, key_valid=0, last=0, busy=0, and clears the BCD and shift registers.
REQ-024 Reset mid-CONVERT or mid-EMIT abandons the operation; no further digits appear after release.
REQ-025 First start is honoured on the first rising edge with reset=1.

Configuration
REQ-026 LEADING_ZERO_SUPPRESS_EN defined: on EMIT entry the index skips to the highest nonzero digit (one extra cycle allowed), so key_valid rises within DATA_W+2 cycles; value 0 emits a single digit 0 with last=1.
REQ-027 LEADING_ZERO_SUPPRESS_EN undefined: the REQ-020 behaviour and REQ-016 timing apply exactly.

Structure
REQ-028 Shared package keypad_pkg holds the FSM state enum, BCD_W=4, the add-3 threshold (5) and KEY_W=8.
REQ-029 A single sub-module bin2bcd_core holds the per-cycle add-3/shift datapath (DATA_W, NUM_DIGITS params); digit_emitter holds the FSM, handshake and digit index.

Verification
REQ-030 value=1234, key_ready=1 -> digits 0,0,0,0,0,0,1,2,3,4 (undefined macro) or 1,2,3,4 (defined); last only on 4.
REQ-031 value=0 with the macro defined -> exactly one digit 0 with last=1, then busy=0.
REQ-032 value=4294967295 -> digits 4,2,9,4,9,6,7,2,9,5; busy returns to 0 one cycle after the last handshake.
REQ-033 key_ready held 0 for 5 cycles on the third digit -> key/last stable throughout; no digit skipped or duplicated.
REQ-034 Second start pulse during CONVERT with value=99 -> ignored; the original digits are emitted; reset pulse mid-EMIT -> key_valid=0 immediately and stays 0.
REQ-035 Round trip: emitted digits fed through the keypad accumulator reproduce the original value for 1000 random 32-bit inputs.
